// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider, result = A / B.
// Restoring shift-subtract mantissa divide, one quotient bit per clock, then a
// normalize/exponent stage. Denormals are flushed to zero; the quotient is truncated.
// Ports: clk, n_rst (async, active-low), start, A, B -> busy, done (1-cycle pulse),
//        result, overflow, underflow, div_by_zero, invalid.
// Latency: done 26 cycles after the start edge (normal), 1 cycle (special case).
// start is ignored while busy; outputs hold until the next accepted start.

module fp_div_seq #(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, SPEC, CALC, NORM} state_t;

  state_t      state;
  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] d;
  logic [25:0] r;
  logic [24:0] q;
  logic [4:0]  count;
  logic [31:0] spec_res;
  logic        spec_inv;
  logic        spec_dz;

  // Operand classification, evaluated on the raw inputs at the start edge.
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic in_sign, is_spec;
  logic [31:0] sp_res;
  logic        sp_inv;
  logic        sp_dz;

  always_comb begin
    a_zero  = (A[30:23] == 8'h00);
    a_inf   = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    a_nan   = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_zero  = (B[30:23] == 8'h00);
    b_inf   = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    b_nan   = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    in_sign = A[31] ^ B[31];
    is_spec = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    sp_res  = {in_sign, 31'd0};
    sp_inv  = 1'b0;
    sp_dz   = 1'b0;
    // Priority order matters: inf/0 yields inf without the divide-by-zero flag.
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = 32'h7FC00000;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_res = {in_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      sp_res = {in_sign, 31'd0};
    end else if (b_zero) begin
      sp_res = {in_sign, 8'hFF, 23'd0};
      sp_dz  = 1'b1;
    end else begin
      sp_res = {in_sign, 31'd0};
    end
  end

  // One restoring step: the partial remainder always stays below 2*D, so 26 bits suffice.
  logic        ge;
  logic [25:0] diff;

  always_comb begin
    ge   = (r >= {2'b00, d});
    diff = r - {2'b00, d};
  end

  // Normalize: mantissa ratio lies in (0.5, 2), so either Q[24] or Q[23] is the leading one.
  logic        adj;
  logic [22:0] frac;
  logic [9:0]  e_calc;
  logic        e_ovf;
  logic        e_unf;

  always_comb begin
    adj    = ~q[24];
    frac   = q[24] ? q[23:1] : q[22:0];
    e_calc = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, adj};
    // e_calc is two's complement; bit 9 set means negative.
    e_unf  = e_calc[9] || (e_calc == 10'd0);
    e_ovf  = !e_calc[9] && (e_calc[8:0] >= 9'd255);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      sign        <= 1'b0;
      ea          <= 8'd0;
      eb          <= 8'd0;
      d           <= 24'd0;
      r           <= 26'd0;
      q           <= 25'd0;
      count       <= 5'd0;
      spec_res    <= 32'd0;
      spec_inv    <= 1'b0;
      spec_dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign        <= in_sign;
            ea          <= A[30:23];
            eb          <= B[30:23];
            d           <= {1'b1, B[22:0]};
            r           <= {2'b00, 1'b1, A[22:0]};
            q           <= 25'd0;
            count       <= ITER[4:0];
            busy        <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            spec_res    <= sp_res;
            spec_inv    <= sp_inv;
            spec_dz     <= sp_dz;
            state       <= is_spec ? SPEC : CALC;
          end
        end
        SPEC: begin
          result      <= spec_res;
          invalid     <= spec_inv;
          div_by_zero <= spec_dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        CALC: begin
          q     <= {q[23:0], ge};
          r     <= ge ? {diff[24:0], 1'b0} : {r[24:0], 1'b0};
          count <= count - 5'd1;
          if (count == 5'd1) state <= NORM;
        end
        NORM: begin
          if (e_ovf) begin
            result   <= {sign, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else if (e_unf) begin
            result    <= {sign, 31'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sign, e_calc[7:0], frac};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed-vector bench for fp_div_seq.
// Table of operands with hand-computed quotients, flags and latencies, plus
// sequences for ignored start, start-on-done and mid-operation reset.

module tb_fp_div_seq;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  int n_total;
  int n_pass;

  fp_div_seq dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .result(result),
    .overflow(overflow),
    .underflow(underflow),
    .div_by_zero(div_by_zero),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {overflow, underflow, div_by_zero, invalid}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  function automatic logic [3:0] flags_now();
    return {overflow, underflow, div_by_zero, invalid};
  endfunction

  initial begin
    int lat;
    int dcount;
    n_total = 0;
    n_pass  = 0;
    start   = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    n_rst   = 1'b0;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26}; // 6/2
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 26}; // 1/3 truncated
    vecs[2]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 26}; // overflow
    vecs[3]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 26}; // underflow e=0
    vecs[4]  = '{32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0010, 1};  // -2/0
    vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1};  // 0/0
    vecs[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 26}; // -6/2
    vecs[7]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26}; // 1/1
    vecs[8]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 26}; // 3/2
    vecs[9]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 4'b0000, 26}; // 1/1.5
    vecs[10] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 1};  // inf/2
    vecs[11] = '{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1};  // -2/inf
    vecs[12] = '{32'h00000000, 32'h40400000, 32'h00000000, 4'b0000, 1};  // 0/3
    vecs[13] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1};  // NaN/1
    vecs[14] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 1};  // inf/-inf
    vecs[15] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1};  // inf/0
    vecs[16] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1};  // denormal flushed
    vecs[17] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b1000, 26}; // e=255 exactly
    vecs[18] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 26}; // e=254
    vecs[19] = '{32'h3F800000, 32'h3FFFFFFF, 32'h3F000000, 4'b0000, 26}; // 1/1.99999988

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {28'd0, flags_now()}, 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      do_start(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {28'd0, flags_now()}, {28'd0, vecs[i].flags});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_hold", i), result, vecs[i].res);
    end

    // start re-pulsed at the 10th edge of a divide is ignored
    do_start(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1;
    A     = 32'h3F800000;
    B     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignored_start_latency", (lat < 0) ? -1 : lat + 10, 26);
    check("ignored_start_result", result, 32'h40400000);

    // start while done is high is accepted
    do_start(32'h3F800000, 32'h40400000);
    check("done_start_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("done_start_latency", lat, 26);
    check("done_start_result", result, 32'h3EAAAAAA);

    // reset in the middle of a divide
    do_start(32'h40C00000, 32'h40000000);
    repeat (11) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {28'd0, flags_now()}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst  = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);
    do_start(32'h40400000, 32'h40000000);
    wait_done(lat);
    check("post_rst_latency", lat, 26);
    check("post_rst_result", result, 32'h3FC00000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, result = A / B.
- Inverse-direction companion to the team's sequential shift-add multiplier.
- Mantissa quotient is built by 25-iteration restoring shift-subtract, one quotient bit per clock. A normalize stage follows, then sign, exponent and special-case resolution.
- Sits beside the multiplier in the FPU datapath and uses a start/busy/done handshake.

Parameters:
- ITER, 25, number of quotient bits produced (1 integer bit + 24 fraction bits). Fixed for single precision; any other value is unsupported.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- A  input  32  dividend, IEEE-754 single.
- B  input  32  divisor, IEEE-754 single.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  32  quotient, IEEE-754 single.
- overflow  output  1  exponent overflow; result is signed infinity.
- underflow  output  1  exponent underflow; result is signed zero (flush).
- div_by_zero  output  1  finite nonzero / zero.
- invalid  output  1  NaN produced: 0/0, inf/inf, or any NaN input.

Behaviour:
- Reset (async, n_rst=0): state=IDLE; busy=0, done=0, result=0, all flags 0; internal registers cleared. Reset mid-operation aborts the divide with no done pulse.
- Input classes: exp==0 is treated as zero (denormals flushed). exp==255 with frac==0 is inf. exp==255 with frac!=0 is NaN.
- States:
  - IDLE: on start=1 at edge E0, latch sign=A[31]^B[31], eA, eB, D={1,B[22:0]}, R={2'b0,1,A[22:0]} (26 bits), Q=0, count=25, busy=1.
  - If the operands are a special case, go to SPEC; otherwise go to CALC.
  - SPEC: at E1 register the special result, done=1, busy=0, return to IDLE.
  - CALC: each edge, if R>=D then Q={Q[23:0],1} and R=(R-D)<<1, else Q={Q[23:0],0} and R=R<<1; count-=1. Edges E1..E25 perform the iterations. On count reaching 0, go to NORM.
  - NORM (E26): normalize, compute exponent, register result and flags, done=1, busy=0, return to IDLE.
- Latency: normal operands give done 26 cycles after the start edge; special cases give done 1 cycle after.
- done is high for exactly one cycle.
- result and flags hold until the next accepted start. A new start clears flags and done at E0.
- start while busy=1 is ignored. start in the cycle done is high is accepted, because the state is already IDLE.
- Normalize:
  - If Q[24]=1: frac=Q[23:1], adj=0.
  - Else: frac=Q[22:0], adj=1 (Q[23] is guaranteed 1).
  - Remainder is discarded; truncation, no rounding.
- Exponent: 10-bit signed, e = eA - eB + 127 - adj.
  - e>=255: result={sign,8'hFF,0}, overflow=1.
  - e<=0: result={sign,31'b0}, underflow=1.
  - Otherwise: result={sign,e[7:0],frac}.
- Special cases, in priority order:
  1. Either input NaN, or 0/0, or inf/inf: result=32'h7FC00000, invalid=1.
  2. inf/finite: {sign,8'hFF,0}.
  3. finite/inf: {sign,31'b0}.
  4. nonzero/0: {sign,8'hFF,0}, div_by_zero=1.
  5. 0/nonzero: {sign,31'b0}.
- At most one flag is set per operation.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000 (2.0), start pulse -> busy for 26 cycles, done 26 cycles after start edge, result=0x40400000, all flags 0.
- A=0x3F800000, B=0x40400000 (1/3) -> result=0x3EAAAAAA (truncated, not 0x3EAAAAAB), Q[24]=0 normalize path.
- A=0x7F000000, B=0x3E800000 -> result=0x7F800000, overflow=1. Then A=0x00800000, B=0x40000000 -> result=0x00000000, underflow=1.
- A=0xC0000000, B=0x00000000 -> done 1 cycle after start, result=0xFF800000, div_by_zero=1. Then A=0, B=0 -> result=0x7FC00000, invalid=1.
- start re-pulsed at cycle 10 of a divide -> ignored, original result delivered at cycle 26. A start coincident with done -> accepted, second result 26 cycles later.
- n_rst asserted at cycle 12 of a divide -> busy, done, result and flags go to 0 immediately; no done pulse after release; next start works normally.
